// File: rtl/fp_issue_seq.sv
// fp_issue_seq: sequences one multi-cycle FP op through the shared FP unit, then writes the result back to the FP register file.
module fp_issue_seq #(
    parameter int ADD_LAT  = 2,
    parameter int MUL_LAT  = 3,
    parameter int DIV_LAT  = 16,
    parameter int SQRT_LAT = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_add,
    input  logic        op_sub,
    input  logic        op_mul,
    input  logic        op_div,
    input  logic        op_sqrt,
    input  logic [4:0]  rd_in,
    input  logic        mem_wait,
    input  logic        flush,
    input  logic        dec_fp_use,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [31:0] fpu_result,
    output logic        fpu_start,
    output logic [2:0]  fpu_op,
    output logic        stall_out,
    output logic        raw_hazard,
    output logic        fp_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        op_err
);
    typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;
    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d, pend_rd_q, pend_rd_d, lat_m1;
    logic [2:0]  fpu_op_q, fpu_op_d, op_enc;
    logic [31:0] wb_data_q, wb_data_d;
    logic        start_q, idle, accept;
    logic [4:0]  ops;
    assign ops = {op_sqrt, op_div, op_mul, op_sub, op_add};
    always_comb begin
        idle   = state_q == IDLE;
        // rst gating keeps every output at zero while reset is held
        accept = rst && idle && $onehot(ops) && !mem_wait && !flush;
        op_err = rst && idle && ops != 5'd0 && !$onehot(ops);
        op_enc = op_sub ? 3'd1 : op_mul ? 3'd2 : op_div ? 3'd3 : op_sqrt ? 3'd4 : 3'd0;
        lat_m1 = op_mul ? 5'(MUL_LAT - 1) : op_div ? 5'(DIV_LAT - 1) :
                 op_sqrt ? 5'(SQRT_LAT - 1) : 5'(ADD_LAT - 1);
    end
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pend_rd_d = pend_rd_q;
        fpu_op_d  = fpu_op_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d   = BUSY;
                fpu_op_d  = op_enc;
                pend_rd_d = rd_in;
                count_d   = lat_m1;
            end
            BUSY: if (flush) state_d = IDLE;
                  else if (count_q == 5'd0) begin
                      wb_data_d = fpu_result;
                      state_d   = WB;
                  end else count_d = count_q - 5'd1;
            WB:   if (flush || !mem_wait) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pend_rd_q <= '0;
            fpu_op_q  <= '0;
            wb_data_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pend_rd_q <= pend_rd_d;
            fpu_op_q  <= fpu_op_d;
            wb_data_q <= wb_data_d;
            start_q   <= accept;
        end
    end
    assign fpu_start  = start_q;
    assign fpu_op     = fpu_op_q;
    assign busy       = !idle;
    assign stall_out  = accept || state_q == BUSY || (state_q == WB && mem_wait);
    assign raw_hazard = dec_fp_use && !idle && (dec_rs1 == pend_rd_q || dec_rs2 == pend_rd_q);
    assign fp_we      = state_q == WB && !flush;
    assign wb_rd      = pend_rd_q;
    assign wb_data    = wb_data_q;
endmodule

// File: tb/tb_fp_issue_seq.sv
// tb_fp_issue_seq: directed checks of fp_issue_seq timing, write-back, hazards, flush and reset.
module tb_fp_issue_seq;
    logic        clk = 0, rst = 0;
    logic        op_add = 0, op_sub = 0, op_mul = 0, op_div = 0, op_sqrt = 0;
    logic [4:0]  rd_in = 0, dec_rs1 = 0, dec_rs2 = 0;
    logic        mem_wait = 0, flush = 0, dec_fp_use = 0;
    logic [31:0] fpu_result = 0;
    logic        fpu_start, stall_out, raw_hazard, fp_we, busy, op_err;
    logic [2:0]  fpu_op;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    int          n_chk = 0, n_pass = 0;
    logic        we_seen;

    fp_issue_seq dut (
        .clk(clk), .rst(rst), .op_add(op_add), .op_sub(op_sub), .op_mul(op_mul),
        .op_div(op_div), .op_sqrt(op_sqrt), .rd_in(rd_in), .mem_wait(mem_wait),
        .flush(flush), .dec_fp_use(dec_fp_use), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .fpu_result(fpu_result), .fpu_start(fpu_start), .fpu_op(fpu_op),
        .stall_out(stall_out), .raw_hazard(raw_hazard), .fp_we(fp_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .busy(busy), .op_err(op_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1;
        check("rst_outs", {fpu_start, fpu_op, stall_out, raw_hazard, fp_we, wb_rd, wb_data, busy, op_err}, 0);
        nxt();
        nxt();
        rst = 1;
        // fadd rd=3
        nxt(); op_add = 1; rd_in = 3; #1;
        check("add_acc_stall", stall_out, 1);
        check("add_acc_start", fpu_start, 0);
        nxt(); op_add = 0; #1;
        check("add_start", fpu_start, 1);
        check("add_op", fpu_op, 0);
        check("add_busy_stall", stall_out, 1);
        nxt(); fpu_result = 32'h40400000; #1;
        check("add_cap_stall", stall_out, 1);
        check("add_cap_we", fp_we, 0);
        check("add_cap_start", fpu_start, 0);
        nxt(); fpu_result = 32'hdeadbeef; #1;
        check("add_we", fp_we, 1);
        check("add_rd", wb_rd, 3);
        check("add_data", wb_data, 32'h40400000);
        check("add_wb_stall", stall_out, 0);
        nxt(); #1;
        check("add_idle", busy, 0);
        check("add_we_off", fp_we, 0);
        check("add_data_hold", wb_data, 32'h40400000);
        // fdiv rd=7 with D-stage hazards
        nxt(); op_div = 1; rd_in = 7; dec_fp_use = 1; dec_rs2 = 7; #1;
        check("div_acc_stall", stall_out, 1);
        check("div_idle_raw", raw_hazard, 0);
        for (int i = 1; i <= 16; i++) begin
            nxt(); op_div = 0;
            dec_rs1 = (i % 2 == 1) ? 5'd8 : 5'd0;
            dec_rs2 = (i % 2 == 1) ? 5'd8 : 5'd7;
            fpu_result = (i == 16) ? 32'h41000000 : 32'h0;
            #1;
            check($sformatf("div_busy%0d", i), busy, 1);
            check($sformatf("div_stall%0d", i), stall_out, 1);
            check($sformatf("div_we%0d", i), fp_we, 0);
            check($sformatf("div_raw%0d", i), raw_hazard, (i % 2 == 1) ? 0 : 1);
            if (i == 1) check("div_op", fpu_op, 3);
        end
        nxt(); dec_rs1 = 7; dec_rs2 = 8; fpu_result = 0; #1;
        check("div_we", fp_we, 1);
        check("div_rd", wb_rd, 7);
        check("div_data", wb_data, 32'h41000000);
        check("div_wb_raw", raw_hazard, 1);
        check("div_wb_stall", stall_out, 0);
        nxt(); #1;
        check("div_idle_raw2", raw_hazard, 0);
        check("div_idle", busy, 0);
        // fmul rd=5 completing under mem_wait
        nxt(); op_mul = 1; rd_in = 5; dec_fp_use = 0; #1;
        check("mul_acc_stall", stall_out, 1);
        for (int i = 1; i <= 3; i++) begin
            nxt(); op_mul = 0; fpu_result = (i == 3) ? 32'h40a00000 : 32'h0; #1;
            check($sformatf("mul_busy%0d", i), busy, 1);
        end
        for (int i = 0; i < 4; i++) begin
            nxt(); mem_wait = (i < 3); #1;
            check($sformatf("mul_we%0d", i), fp_we, 1);
            check($sformatf("mul_rd%0d", i), wb_rd, 5);
            check($sformatf("mul_data%0d", i), wb_data, 32'h40a00000);
            check($sformatf("mul_stall%0d", i), stall_out, (i < 3) ? 1 : 0);
        end
        nxt(); mem_wait = 0; #1;
        check("mul_idle", busy, 0);
        check("mul_we_off", fp_we, 0);
        // multi-hot op
        nxt(); op_add = 1; op_mul = 1; #1;
        check("err_pulse", op_err, 1);
        check("err_stall", stall_out, 0);
        nxt(); op_add = 0; op_mul = 0; #1;
        check("err_idle", busy, 0);
        check("err_start", fpu_start, 0);
        check("err_off", op_err, 0);
        // flush in IDLE blocks accept
        nxt(); op_add = 1; flush = 1; #1;
        check("iflush_stall", stall_out, 0);
        nxt(); op_add = 0; flush = 0; #1;
        check("iflush_idle", busy, 0);
        // fsub rd=2
        nxt(); op_sub = 1; rd_in = 2; #1;
        nxt(); op_sub = 0; #1;
        check("sub_op", fpu_op, 1);
        check("sub_start", fpu_start, 1);
        nxt();
        nxt(); #1;
        check("sub_we", fp_we, 1);
        check("sub_rd", wb_rd, 2);
        nxt(); #1;
        check("sub_idle", busy, 0);
        // fsqrt rd=9 flushed in BUSY cycle 5
        we_seen = 0;
        nxt(); op_sqrt = 1; rd_in = 9; #1;
        for (int i = 1; i <= 5; i++) begin
            nxt(); op_sqrt = 0; flush = (i == 5); #1;
            we_seen |= fp_we;
            check($sformatf("sqrt_busy%0d", i), busy, 1);
        end
        check("sqrt_flush_we", fp_we, 0);
        check("sqrt_op", fpu_op, 4);
        for (int i = 6; i <= 22; i++) begin
            nxt(); flush = 0; #1;
            we_seen |= fp_we;
            if (i == 6) check("sqrt_flush_idle", busy, 0);
        end
        check("sqrt_no_we", we_seen, 0);
        // async reset mid-BUSY
        nxt(); op_mul = 1; rd_in = 4; dec_fp_use = 1; dec_rs1 = 4; #1;
        nxt(); op_mul = 0; #1;
        check("rmid_busy", busy, 1);
        check("rmid_raw", raw_hazard, 1);
        #3; rst = 0; #1;
        check("rmid_outs", {fpu_start, fpu_op, stall_out, raw_hazard, fp_we, wb_rd, wb_data, busy, op_err}, 0);
        we_seen = 0;
        nxt(); rst = 1; dec_fp_use = 0; #1;
        for (int i = 0; i < 5; i++) begin
            nxt(); #1;
            we_seen |= fp_we;
        end
        check("rmid_no_we", we_seen, 0);
        check("rmid_idle", busy, 0);
        // back-to-back fadd rd=1 then rd=2
        nxt(); op_add = 1; rd_in = 1; fpu_result = 32'h3f800000; #1;
        check("b2b_acc1", stall_out, 1);
        nxt(); #1;
        check("b2b_start1", fpu_start, 1);
        nxt();
        nxt(); #1;
        check("b2b_we1", fp_we, 1);
        check("b2b_rd1", wb_rd, 1);
        check("b2b_data1", wb_data, 32'h3f800000);
        check("b2b_wb_stall", stall_out, 0);
        nxt(); rd_in = 2; fpu_result = 32'h40000000; #1;
        check("b2b_acc2", stall_out, 1);
        check("b2b_gap_we", fp_we, 0);
        nxt(); op_add = 0; #1;
        check("b2b_start2", fpu_start, 1);
        nxt();
        nxt(); #1;
        check("b2b_we2", fp_we, 1);
        check("b2b_rd2", wb_rd, 2);
        check("b2b_data2", wb_data, 32'h40000000);
        nxt(); #1;
        check("b2b_idle", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
